// File: rtl/pool_stream_kxk_if.sv
// Pixel-in / pooled-out stream bundle for pool_stream_kxk.
// The design side is the slave modport; the producer/consumer side is the master.
interface pool_stream_kxk_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 1
) ();
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH*DATA_W-1:0] pixel_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH*DATA_W-1:0] pool_out;
  logic                 out_last;
  logic                 frame_done;

  modport master (
    output mode, in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, pool_out, out_last, frame_done
  );

  modport slave (
    input  mode, in_valid, pixel_in, out_ready,
    output in_ready, out_valid, pool_out, out_last, frame_done
  );
endinterface

// File: rtl/pool_stream_kxk.sv
// Streaming non-overlapping KxK max/average pooling over a raster pixel stream.
// One partial result per output column per channel; the result is registered on the completing beat.
module pool_stream_kxk #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int CH     = 1,
  parameter int K      = 2
) (
  input logic              clk,
  input logic              rst,
  pool_stream_kxk_if.slave bus
);
  localparam int LK    = (K == 4) ? 2 : 1;
  localparam int SH    = 2 * LK;
  localparam int SUM_W = DATA_W + SH;
  localparam int OUT_W = IMG_W / K;
  localparam int OUT_H = IMG_H / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic                    r_mode;
  logic signed [SUM_W-1:0] r_acc [OUT_W][CH];
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [CH*DATA_W-1:0]    r_pool_out;
  logic                    r_frame_done;

  logic                    w_accept;
  logic                    w_origin;
  logic                    w_col_end;
  logic                    w_row_end;
  logic                    w_in_crop;
  logic                    w_first;
  logic                    w_blk_end;
  logic                    w_last_blk;
  logic                    w_mode;
  logic [CW-1:0]           w_ocol;
  logic [RW-1:0]           w_orow;
  logic signed [SUM_W-1:0] w_x   [CH];
  logic signed [SUM_W-1:0] w_old [CH];
  logic signed [SUM_W-1:0] w_new [CH];
  logic signed [DATA_W-1:0] w_avg [CH];
  logic [CH*DATA_W-1:0]    w_result;

  assign bus.in_ready   = !r_out_valid || bus.out_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.pool_out   = r_pool_out;
  assign bus.frame_done = r_frame_done;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_origin   = (r_col == '0) && (r_row == '0);
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_row_end  = (r_row == RW'(IMG_H - 1));
  assign w_ocol     = r_col >> LK;
  assign w_orow     = r_row >> LK;
  // Block coordinates past the last whole block fall in the cropped margin.
  assign w_in_crop  = (w_ocol < CW'(OUT_W)) && (w_orow < RW'(OUT_H));
  assign w_first    = (r_col[LK-1:0] == '0) && (r_row[LK-1:0] == '0);
  assign w_blk_end  = (&r_col[LK-1:0]) && (&r_row[LK-1:0]);
  assign w_last_blk = (w_ocol == CW'(OUT_W - 1)) && (w_orow == RW'(OUT_H - 1));
  assign w_mode     = w_origin ? bus.mode : r_mode;

  always_comb begin
    w_result = '0;
    for (int c = 0; c < CH; c++) begin
      w_x[c] = {{SH{bus.pixel_in[c*DATA_W + DATA_W - 1]}}, bus.pixel_in[c*DATA_W +: DATA_W]};
      w_old[c] = '0;
      for (int o = 0; o < OUT_W; o++) begin
        if (w_ocol == CW'(o)) w_old[c] = r_acc[o][c];
      end
      if (w_first)     w_new[c] = w_x[c];
      else if (w_mode) w_new[c] = w_old[c] + w_x[c];
      else             w_new[c] = (w_x[c] > w_old[c]) ? w_x[c] : w_old[c];
      w_avg[c] = DATA_W'(w_new[c] >>> SH);
      w_result[c*DATA_W +: DATA_W] = w_mode ? w_avg[c] : DATA_W'(w_new[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_mode       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_pool_out   <= '0;
      r_frame_done <= 1'b0;
      for (int o = 0; o < OUT_W; o++)
        for (int c = 0; c < CH; c++)
          r_acc[o][c] <= '0;
    end else begin
      r_frame_done <= w_accept && w_col_end && w_row_end;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        if (w_origin) r_mode <= bus.mode;
        r_col <= w_col_end ? '0 : r_col + CW'(1);
        if (w_col_end) r_row <= w_row_end ? '0 : r_row + RW'(1);
        if (w_in_crop) begin
          for (int o = 0; o < OUT_W; o++) begin
            if (w_ocol == CW'(o))
              for (int c = 0; c < CH; c++) r_acc[o][c] <= w_new[c];
          end
          // A completing beat overrides the pop above, so back-to-back results never bubble.
          if (w_blk_end) begin
            r_out_valid <= 1'b1;
            r_pool_out  <= w_result;
            r_out_last  <= w_last_blk;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_stream_kxk.sv
// Bench for pool_stream_kxk: three geometries (8x8 K=2 CH=2, 5x5 K=2 cropped, 10x9 K=4 cropped)
// driven with ramps, crafted blocks and random frames against a block-level reference model.
module tb_pool_stream_kxk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_cfg = 0;
  int   fr [0:127][0:1];
  int   q0[$];
  int   q1[$];
  bit   ql[$];
  bit   pv_st [3];
  int   pv_d  [3];
  bit   pv_l  [3];

  always #5 clk = ~clk;

  pool_stream_kxk_if #(.DATA_W(8), .CH(2)) ifa ();
  pool_stream_kxk_if #(.DATA_W(8), .CH(1)) ifb ();
  pool_stream_kxk_if #(.DATA_W(8), .CH(1)) ifc ();

  pool_stream_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .CH(2), .K(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pool_stream_kxk #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .CH(1), .K(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pool_stream_kxk #(.DATA_W(8), .IMG_W(10), .IMG_H(9), .CH(1), .K(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Expected results for the first lim block rows of the frame held in fr.
  function automatic void model(input int iw, input int ih, input int k, input int nch, input bit md, input int lim);
    int ow, oh, s, m, v;
    int e [2];
    ow = iw / k;
    oh = ih / k;
    for (int by = 0; by < lim; by++) begin
      for (int bx = 0; bx < ow; bx++) begin
        for (int c = 0; c < 2; c++) begin
          s = 0;
          m = -1000;
          for (int dy = 0; dy < k; dy++) begin
            for (int dx = 0; dx < k; dx++) begin
              v = (c < nch) ? fr[(by*k + dy)*iw + bx*k + dx][c] : 0;
              s += v;
              if (v > m) m = v;
            end
          end
          e[c] = md ? floor_div(s, k*k) : m;
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
        ql.push_back(by == oh-1 && bx == ow-1);
      end
    end
  endfunction

  task automatic build(input int iw, input int ih, input int kind);
    int ext [5] = '{-128, 127, -1, 0, 1};
    int r, c, b, o;
    for (int i = 0; i < iw*ih; i++) begin
      r = i / iw;
      c = i % iw;
      fr[i][0] = int'($urandom_range(0, 255)) - 128;
      fr[i][1] = int'($urandom_range(0, 255)) - 128;
      if (kind == 0) begin
        fr[i][0] = r*iw + c;
        fr[i][1] = -(r*iw + c);
      end else if (kind == 2) begin
        fr[i][0] = ext[$urandom_range(0, 4)];
        fr[i][1] = ext[$urandom_range(0, 4)];
      end else if (kind == 3 && r < 2 && c < 6) begin
        b = c / 2;
        o = (r % 2)*2 + (c % 2);
        if (b == 0)      fr[i][0] = (o == 0) ? -3 : -2;
        else if (b == 1) fr[i][0] = (o == 0) ? 1 : 2;
        else             fr[i][0] = -128;
      end
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [15:0] d, input logic m);
    case (w)
      0:       begin ifa.in_valid = v; ifa.pixel_in = d;      ifa.mode = m; end
      1:       begin ifb.in_valid = v; ifb.pixel_in = d[7:0]; ifb.mode = m; end
      default: begin ifc.in_valid = v; ifc.pixel_in = d[7:0]; ifc.mode = m; end
    endcase
  endtask

  function automatic logic get_rdy(input int w);
    case (w)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  function automatic logic get_fd(input int w);
    case (w)
      0:       return ifa.frame_done;
      1:       return ifb.frame_done;
      default: return ifc.frame_done;
    endcase
  endfunction

  task automatic send(input int w, input logic [15:0] d, input logic m, input bit lastpx);
    int t = 0;
    set_in(w, 1'b1, d, m);
    forever begin
      @(negedge clk);
      if (get_rdy(w)) break;
      t++;
      if (t > 300) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    check("frame_done", int'(get_fd(w)), int'(lastpx));
  endtask

  task automatic stream(input int w, input int iw, input int ih, input bit md, input int n_send, input bit gaps);
    for (int i = 0; i < n_send; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        set_in(w, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      send(w, {8'(fr[i][1]), 8'(fr[i][0])}, (i == 0) ? md : 1'($urandom_range(0, 1)), i == iw*ih - 1);
    end
    set_in(w, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while (q0.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("queue_drained", q0.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_out_valid_a", int'(ifa.out_valid), 0);
    check("rst_pool_out_a", int'(ifa.pool_out), 0);
    check("rst_out_last_a", int'(ifa.out_last), 0);
    check("rst_frame_done_a", int'(ifa.frame_done), 0);
    check("rst_out_valid_b", int'(ifb.out_valid), 0);
    check("rst_out_valid_c", int'(ifc.out_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready_a", int'(ifa.in_ready), 1);
    check("post_rst_out_valid_a", int'(ifa.out_valid), 0);
  endtask

  task automatic cmp(input int w, input logic ov, input logic ordy, input logic [7:0] p0,
                     input logic [7:0] p1, input logic ol, input logic ir);
    int e0, e1;
    bit el;
    if (rst) begin
      pv_st[w] = 1'b0;
      return;
    end
    check("in_ready_rule", int'(ir), int'(!ov || ordy));
    if (pv_st[w]) begin
      check("stall_valid_held", int'(ov), 1);
      check("stall_data_held", int'({p1, p0}), pv_d[w]);
      check("stall_last_held", int'(ol), int'(pv_l[w]));
    end
    if (ov && ordy) begin
      if (q0.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        el = ql.pop_front();
        check("pool_ch0", int'($signed(p0)), e0);
        if (w == 0) check("pool_ch1", int'($signed(p1)), e1);
        check("out_last", int'(ol), int'(el));
      end
    end
    pv_st[w] = ov && !ordy;
    pv_d[w]  = int'({p1, p0});
    pv_l[w]  = ol;
  endtask

  always @(negedge clk) begin
    cmp(0, ifa.out_valid, ifa.out_ready, ifa.pool_out[7:0], ifa.pool_out[15:8], ifa.out_last, ifa.in_ready);
    cmp(1, ifb.out_valid, ifb.out_ready, ifb.pool_out, 8'h00, ifb.out_last, ifb.in_ready);
    cmp(2, ifc.out_valid, ifc.out_ready, ifc.pool_out, 8'h00, ifc.out_last, ifc.in_ready);
  end

  initial begin
    logic r;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      r = (rdy_cfg == 0) ? 1'b1 : (rdy_cfg == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      ifa.out_ready = r;
      ifb.out_ready = r;
      ifc.out_ready = r;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit md;
    set_in(0, 1'b0, 16'h0, 1'b0);
    set_in(1, 1'b0, 16'h0, 1'b0);
    set_in(2, 1'b0, 16'h0, 1'b0);
    do_reset();

    // 8x8 ramp, max, ch1 = -ramp
    build(8, 8, 0);
    model(8, 8, 2, 2, 1'b0, 4);
    check("pin_ramp_first", q0[0], 9);
    check("pin_ramp_second", q0[1], 11);
    check("pin_ramp_row1", q0[4], 25);
    check("pin_ramp_last", q0[15], 63);
    check("pin_ch1_first", q1[0], 0);
    check("pin_last_flag", int'(ql[15]), 1);
    check("pin_not_last", int'(ql[14]), 0);
    stream(0, 8, 8, 1'b0, 64, 1'b0);
    drain();

    // Output stall of 10 cycles on the first result
    rdy_cfg = 2;
    build(8, 8, 0);
    model(8, 8, 2, 2, 1'b0, 4);
    fork
      stream(0, 8, 8, 1'b0, 64, 1'b0);
    join_none
    t = 0;
    while (!ifa.out_valid && t < 100) begin @(negedge clk); t++; end
    check("bp_first_valid", int'(ifa.out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_valid", int'(ifa.out_valid), 1);
      check("bp_hold_data", int'($signed(ifa.pool_out[7:0])), 9);
      check("bp_in_ready_low", int'(ifa.in_ready), 0);
    end
    rdy_cfg = 0;
    wait fork;
    drain();

    // Average with negative floor rounding; mode toggles after the origin pixel
    build(8, 8, 3);
    model(8, 8, 2, 2, 1'b1, 4);
    check("pin_avg_neg_floor", q0[0], -3);
    check("pin_avg_pos", q0[1], 1);
    check("pin_avg_min", q0[2], -128);
    stream(0, 8, 8, 1'b1, 64, 1'b0);
    drain();

    // Back-to-back random frames with random backpressure and input gaps
    rdy_cfg = 1;
    for (int f = 0; f < 4; f++) begin
      build(8, 8, (f % 2 == 0) ? 1 : 2);
      md = 1'($urandom_range(0, 1));
      model(8, 8, 2, 2, md, 4);
      stream(0, 8, 8, md, 64, 1'b1);
    end
    drain();

    // Reset after 20 accepts, then a clean ramp frame
    rdy_cfg = 0;
    build(8, 8, 0);
    model(8, 8, 2, 2, 1'b0, 1);
    stream(0, 8, 8, 1'b0, 20, 1'b0);
    drain();
    do_reset();
    build(8, 8, 0);
    model(8, 8, 2, 2, 1'b0, 4);
    stream(0, 8, 8, 1'b0, 64, 1'b0);
    drain();

    // 5x5 cropped, K=2
    build(5, 5, 0);
    model(5, 5, 2, 1, 1'b0, 2);
    check("pin_crop_0", q0[0], 6);
    check("pin_crop_1", q0[1], 8);
    check("pin_crop_2", q0[2], 16);
    check("pin_crop_3", q0[3], 18);
    check("pin_crop_last", int'(ql[3]), 1);
    stream(1, 5, 5, 1'b0, 25, 1'b0);
    rdy_cfg = 1;
    build(5, 5, 1);
    model(5, 5, 2, 1, 1'b1, 2);
    stream(1, 5, 5, 1'b1, 25, 1'b1);
    drain();

    // 10x9 cropped, K=4
    rdy_cfg = 0;
    build(10, 9, 0);
    model(10, 9, 4, 1, 1'b0, 2);
    check("pin_k4_0", q0[0], 33);
    check("pin_k4_1", q0[1], 37);
    check("pin_k4_2", q0[2], 73);
    check("pin_k4_3", q0[3], 77);
    stream(2, 10, 9, 1'b0, 90, 1'b0);
    rdy_cfg = 1;
    build(10, 9, 2);
    model(10, 9, 4, 1, 1'b1, 2);
    stream(2, 10, 9, 1'b1, 90, 1'b1);
    build(10, 9, 1);
    model(10, 9, 4, 1, 1'b1, 2);
    stream(2, 10, 9, 1'b1, 90, 1'b1);
    build(10, 9, 1);
    model(10, 9, 4, 1, 1'b0, 2);
    stream(2, 10, 9, 1'b0, 90, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pool_stream_kxk.md
Name: pool_stream_kxk

Overview:
- Streaming non-overlapping KxK pooling engine with a selectable max or average mode.
- Consumes a raster-order pixel stream, CH channels packed per beat, and emits one pooled beat per completed KxK block.
- Holds a per-output-column partial result instead of full line copies.
- Sits between the conv/activation output stream and the next layer; full valid/ready backpressure on both sides.

Parameters:
- DATA_W, 8, signed sample width per channel.
- IMG_W, 8, input frame width in pixels.
- IMG_H, 8, input frame height in pixels.
- CH, 1, channels packed per beat; channel c occupies bits [c*DATA_W +: DATA_W].
- K, 2, window size and stride; legal values 2 or 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mode  in  1  0 = max pool, 1 = average pool; sampled only at the first pixel of a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- pixel_in  in  CH*DATA_W  packed signed input samples
- out_valid  out  1  pooled beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- pool_out  out  CH*DATA_W  packed signed pooled samples
- out_last  out  1  qualifies the final pooled beat of a frame
- frame_done  out  1  one-cycle pulse when the last input pixel of a frame is accepted

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - out_valid=0, pool_out=0, out_last=0, frame_done=0.
  - col/row counters=0; mode latch=0; partial-result array cleared.
  - in_ready=1 one cycle after reset deasserts.
  - A reset mid-frame discards all partial blocks and any pending output; the next accepted beat is treated as pixel (0,0).
- Geometry: OUT_W = IMG_W/K and OUT_H = IMG_H/K, floor division.
  - Pixels with col >= OUT_W*K or row >= OUT_H*K are accepted and counted but never contribute to any output (cropping).
- Counters:
  - col advances 0..IMG_W-1 on each accepted beat, then wraps to 0 and row increments.
  - row wraps 0 after IMG_H-1; frame_done pulses on that same accept.
  - Frames are back-to-back with no gap required.
- Mode latch: mode is captured when pixel (0,0) is accepted and held for the whole frame.
- Datapath, per channel:
  - Partial array acc[OUT_W], each entry SUM_W = DATA_W+2*log2(K) bits signed.
  - First pixel of a block (row%K==0, col%K==0) loads acc. Every other in-block pixel updates it: max(acc, x) in max mode, acc + x (sign-extended) in average mode.
  - Max mode: a compare of equal values keeps acc. Average mode: no overflow is possible by construction of SUM_W.
- Output generation:
  - The beat at row%K==K-1 and col%K==K-1 (inside the cropped region) completes a block.
  - On the clock edge that accepts it, pool_out is registered and out_valid is set, so the result appears on the following cycle (latency 1).
  - Max mode: pool_out = acc result truncated to DATA_W; it always fits.
  - Average mode: pool_out = (final sum) >>> (2*log2(K)), arithmetic shift, floor rounding toward -inf.
  - out_last=1 iff the block is at output position (OUT_H-1, OUT_W-1).
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - out_valid stays high with pool_out and out_last stable until accepted.
  - If out_valid && out_ready and a completing beat is accepted on the same cycle, the new result replaces the old with out_valid held at 1 (no bubble).
  - Non-completing beats never touch the output register.
  - When in_valid=0, no state changes except the output handshake.
- frame_done depends only on input acceptance and is independent of output backpressure.

Test Plan:
- Max, 8x8 ramp: K=2, CH=1, pixel=row*8+col, mode=0, out_ready=1 -> 16 outputs 9,11,13,15,25,...,63; out_last only with 63; frame_done one pulse on the 64th accept.
- Average, negative floor: mode=1, block {-3,-2,-2,-2} -> pool_out=-3 (-9>>>2). Block {1,2,2,2} -> 1. Block {-128,-128,-128,-128} -> -128.
- Cropping: IMG_W=5, IMG_H=5, ramp -> 4 outputs {6,8,16,18} in max mode; col 4 and row 4 pixels ignored; frame_done after the 25th accept.
- Backpressure: out_ready held 0 for 10 cycles after the first output -> out_valid held with pool_out=9; in_ready=0; no input lost. Release -> remaining outputs in order, identical to the unstalled run.
- Multi-channel and mode latch: CH=2, ch0=ramp, ch1=-ramp; mode toggled mid-frame -> the whole frame uses the mode sampled at (0,0). Max-mode result: ch0=9, ch1=0 (max of {0,-1,-8,-9}).
- Reset mid-frame: rst asserted after 20 accepts, then a fresh ramp frame -> outputs identical to the clean-frame run; no stale output beat appears.
